// File: rtl/cross_bar_pkg.sv
// Shared types and helpers for the round-robin request/ack crossbar.
// Master and slave numbers are 1-based; 0 means "none".
package cross_bar_pkg;

  localparam int MASTER_N = 4;
  localparam int SLAVE_N  = 4;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_N    = 16;
  localparam int MASTER_W = $clog2(MAX_N + 1);
  localparam int SLAVE_W  = $clog2(MAX_N + 1);

  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [MASTER_W-1:0] master_num_t;
  typedef logic [SLAVE_W-1:0]  slave_num_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  // First set candidate strictly after ptr, wrapping n -> 1.
  function automatic master_num_t rr_pick(
    input logic [MAX_N:1] cand,
    input master_num_t    ptr,
    input int             n
  );
    master_num_t pick;
    int          idx;
    pick = '0;
    for (int i = MAX_N; i >= 1; i--) begin
      if (i <= n) begin
        idx = ((int'(ptr) + i - 1) % n) + 1;
        if (cand[idx]) pick = master_num_t'(idx);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/cross_bar_rr_arb.sv
// Per-slave round-robin arbiter with a grant held until ack or req drop.
// Grant output is 0 whenever the slave is not actively serving anyone.
module cross_bar_rr_arb
  import cross_bar_pkg::*;
#(
  parameter int NUM_M = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [NUM_M:1] cand,
  input  logic [NUM_M:1] req,
  input  logic        slave_ack,
  output master_num_t grant,
  output logic        ack
);

  arb_state_t     state_q, state_d;
  master_num_t    grant_q, grant_d;
  master_num_t    ptr_q, ptr_d;
  logic [MAX_N:1] cand_ext;
  logic           req_g;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= master_num_t'(NUM_M);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    cand_ext = '0;
    cand_ext[NUM_M:1] = cand;
    req_g = 1'b0;
    for (int i = 1; i <= NUM_M; i++) begin
      if (grant_q == master_num_t'(i)) req_g = req[i];
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (|cand) begin
          grant_d = rr_pick(cand_ext, ptr_q, NUM_M);
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // A dropped req abandons the transfer without moving the pointer.
        if (!req_g) begin
          state_d = ARB_IDLE;
          grant_d = '0;
        end else if (slave_ack) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          ptr_d   = grant_q;
        end
      end
    endcase
  end

  always_comb begin
    grant = '0;
    ack   = 1'b0;
    if (state_q == ARB_BUSY && req_g) begin
      grant = grant_q;
      ack   = slave_ack;
    end
  end

endmodule

// File: rtl/cross_bar_rr.sv
// MASTER_N x SLAVE_N req/ack crossbar: address decode, per-slave
// round-robin arbiters, return muxes and an unmapped-address responder.
module cross_bar_rr #(
  parameter int MASTER_N = cross_bar_pkg::MASTER_N,
  parameter int SLAVE_N  = cross_bar_pkg::SLAVE_N,
  parameter int ADDR_W   = cross_bar_pkg::ADDR_W,
  parameter int DATA_W   = cross_bar_pkg::DATA_W,
  parameter int SEL_W    = (SLAVE_N > 1) ? $clog2(SLAVE_N) : 1
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic [MASTER_N:1]             master_req,
  input  logic [MASTER_N:1][ADDR_W-1:0] master_addr,
  input  logic [MASTER_N:1]             master_cmd,
  input  logic [MASTER_N:1][DATA_W-1:0] master_wdata,
  output logic [MASTER_N:1]             master_ack,
  output logic [MASTER_N:1][DATA_W-1:0] master_rdata,
  output logic [SLAVE_N:1]              slave_req,
  output logic [SLAVE_N:1][ADDR_W-1:0]  slave_addr,
  output logic [SLAVE_N:1]              slave_cmd,
  output logic [SLAVE_N:1][DATA_W-1:0]  slave_wdata,
  input  logic [SLAVE_N:1]              slave_ack,
  input  logic [SLAVE_N:1][DATA_W-1:0]  slave_rdata
);

  typedef cross_bar_pkg::slave_num_t  slave_num_t;
  typedef cross_bar_pkg::master_num_t master_num_t;

  slave_num_t  tgt [MASTER_N:1];
  logic [MASTER_N:1] mapped;
  logic [SLAVE_N:1][MASTER_N:1] cand;
  master_num_t arb_grant [SLAVE_N:1];
  logic [SLAVE_N:1]  arb_ack;
  logic [MASTER_N:1] err_q, err_d;
  logic [MASTER_N:1] err_ack;

  always_comb begin
    for (int m = 1; m <= MASTER_N; m++) begin
      tgt[m] = slave_num_t'(master_addr[m][ADDR_W-1 -: SEL_W])
             + slave_num_t'(1);
      mapped[m] = (tgt[m] <= slave_num_t'(SLAVE_N));
    end
  end

  always_comb begin
    for (int s = 1; s <= SLAVE_N; s++) begin
      for (int m = 1; m <= MASTER_N; m++) begin
        cand[s][m] = master_req[m] & mapped[m]
                   & (tgt[m] == slave_num_t'(s));
      end
    end
  end

  for (genvar s = 1; s <= SLAVE_N; s++) begin : g_arb
    cross_bar_rr_arb #(
      .NUM_M(MASTER_N)
    ) u_arb (
      .clk      (clk),
      .rst_n    (aresetn),
      .cand     (cand[s]),
      .req      (master_req),
      .slave_ack(slave_ack[s]),
      .grant    (arb_grant[s]),
      .ack      (arb_ack[s])
    );
  end

  // Flag toggles so a held unmapped req is acked every other cycle.
  always_comb begin
    for (int m = 1; m <= MASTER_N; m++) begin
      err_d[m]   = master_req[m] & ~mapped[m] & ~err_q[m];
      err_ack[m] = err_q[m] & master_req[m];
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  always_comb begin
    slave_req   = '0;
    slave_addr  = '0;
    slave_cmd   = '0;
    slave_wdata = '0;
    for (int s = 1; s <= SLAVE_N; s++) begin
      for (int m = 1; m <= MASTER_N; m++) begin
        if (arb_grant[s] == master_num_t'(m)) begin
          slave_req[s]   = 1'b1;
          slave_addr[s]  = master_addr[m];
          slave_cmd[s]   = master_cmd[m];
          slave_wdata[s] = master_wdata[m];
        end
      end
    end
  end

  always_comb begin
    master_ack   = err_ack;
    master_rdata = '0;
    for (int s = 1; s <= SLAVE_N; s++) begin
      for (int m = 1; m <= MASTER_N; m++) begin
        if (arb_ack[s] && arb_grant[s] == master_num_t'(m)) begin
          master_ack[m]   = 1'b1;
          master_rdata[m] = slave_rdata[s];
        end
      end
    end
  end

endmodule

// File: tb/tb_cross_bar_rr.sv
// Directed bench for cross_bar_rr: a 4x4 instance plus a 4x3 instance
// for the unmapped-address responder.
module tb_cross_bar_rr;

  localparam int MN = 4;
  localparam int SN = 4;
  localparam int BN = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic aresetn = 1'b0;

  logic [MN:1]         m_req, m_cmd, m_ack;
  logic [MN:1][AW-1:0] m_addr;
  logic [MN:1][DW-1:0] m_wdata, m_rdata;
  logic [SN:1]         s_req, s_cmd, s_ack;
  logic [SN:1][AW-1:0] s_addr;
  logic [SN:1][DW-1:0] s_wdata, s_rdata;

  logic [MN:1]         b_m_req, b_m_cmd, b_m_ack;
  logic [MN:1][AW-1:0] b_m_addr;
  logic [MN:1][DW-1:0] b_m_wdata, b_m_rdata;
  logic [BN:1]         b_s_req, b_s_cmd, b_s_ack;
  logic [BN:1][AW-1:0] b_s_addr;
  logic [BN:1][DW-1:0] b_s_wdata, b_s_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cross_bar_rr #(
    .MASTER_N(MN), .SLAVE_N(SN), .ADDR_W(AW), .DATA_W(DW)
  ) u_dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .master_req  (m_req),
    .master_addr (m_addr),
    .master_cmd  (m_cmd),
    .master_wdata(m_wdata),
    .master_ack  (m_ack),
    .master_rdata(m_rdata),
    .slave_req   (s_req),
    .slave_addr  (s_addr),
    .slave_cmd   (s_cmd),
    .slave_wdata (s_wdata),
    .slave_ack   (s_ack),
    .slave_rdata (s_rdata)
  );

  cross_bar_rr #(
    .MASTER_N(MN), .SLAVE_N(BN), .ADDR_W(AW), .DATA_W(DW)
  ) u_dut_b (
    .clk         (clk),
    .aresetn     (aresetn),
    .master_req  (b_m_req),
    .master_addr (b_m_addr),
    .master_cmd  (b_m_cmd),
    .master_wdata(b_m_wdata),
    .master_ack  (b_m_ack),
    .master_rdata(b_m_rdata),
    .slave_req   (b_s_req),
    .slave_addr  (b_s_addr),
    .slave_cmd   (b_s_cmd),
    .slave_wdata (b_s_wdata),
    .slave_ack   (b_s_ack),
    .slave_rdata (b_s_rdata)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
    s_ack = '0;
    s_rdata = {SN{32'hA5A5_A5A5}};
    b_m_req = '0; b_m_cmd = '0; b_m_addr = '0; b_m_wdata = '0;
    b_s_ack = '0;
    b_s_rdata = {BN{32'hFFFF_FFFF}};

    // reset state, with a request pending to prove outputs stay quiet
    m_req[1] = 1'b1;
    m_addr[1] = 32'h4000_0000;
    tick(); tick();
    chk("rst_sreq", 64'(s_req), 64'h0);
    chk("rst_mack", 64'(m_ack), 64'h0);
    chk("rst_saddr", 64'(|s_addr), 64'h0);
    chk("rst_mrdata", 64'(|m_rdata), 64'h0);
    m_req = '0;
    aresetn = 1'b1;
    tick();

    // single read M1 -> S2
    m_req[1] = 1'b1; m_addr[1] = 32'h4000_0000; m_cmd[1] = 1'b0;
    s_rdata[2] = 32'hDEAD_BEEF;
    #1;
    chk("rd_lat0", 64'(s_req), 64'h0);
    tick();
    chk("rd_sreq", 64'(s_req), 64'b0010);
    chk("rd_saddr", 64'(s_addr[2]), 64'h4000_0000);
    chk("rd_noack", 64'(m_ack), 64'h0);
    chk("rd_rd0", 64'(m_rdata[1]), 64'h0);
    tick(); tick(); tick();
    s_ack[2] = 1'b1;
    #1;
    chk("rd_ack", 64'(m_ack), 64'b0001);
    chk("rd_data", 64'(m_rdata[1]), 64'hDEAD_BEEF);
    chk("rd_other", 64'(|m_rdata[4:2]), 64'h0);
    chk("rd_sother", 64'(s_req), 64'b0010);
    tick();
    m_req[1] = 1'b0; s_ack[2] = 1'b0;
    #1;
    chk("rd_idle", 64'(s_req), 64'h0);
    chk("rd_ackoff", 64'(m_ack), 64'h0);

    // contention on S1, ack every busy cycle
    m_req = 4'hF;
    for (int m = 1; m <= MN; m++) m_addr[m] = 32'h0000_0010;
    s_ack[1] = 1'b1;
    for (int k = 1; k <= MN; k++) begin
      tick();
      chk("cont_ack", 64'(m_ack), 64'(4'b0001 << (k - 1)));
      tick();
      m_req[k] = 1'b0;
      #1;
      chk("cont_bub", 64'(m_ack), 64'h0);
    end
    m_req[1] = 1'b1;
    tick();
    chk("cont_m1", 64'(m_ack), 64'b0001);
    tick();
    m_req = 4'hF;
    #1;
    tick();
    chk("cont_m2", 64'(m_ack), 64'b0010);
    tick();
    m_req = '0; s_ack = '0;
    #1;

    // parallel M1 -> S3 write, M2 -> S4 read
    m_req[1] = 1'b1; m_addr[1] = 32'h8000_0000;
    m_cmd[1] = 1'b1; m_wdata[1] = 32'h0000_1234;
    m_req[2] = 1'b1; m_addr[2] = 32'hC000_0000;
    m_cmd[2] = 1'b0; m_wdata[2] = 32'h0;
    tick();
    chk("par_sreq", 64'(s_req), 64'b1100);
    chk("par_addr3", 64'(s_addr[3]), 64'h8000_0000);
    chk("par_addr4", 64'(s_addr[4]), 64'hC000_0000);
    chk("par_cmd", 64'(s_cmd), 64'b0100);
    chk("par_wd3", 64'(s_wdata[3]), 64'h1234);
    chk("par_wd4", 64'(s_wdata[4]), 64'h0);
    s_ack[4] = 1'b1; s_rdata[4] = 32'h5555_0000;
    #1;
    chk("par_ack2", 64'(m_ack), 64'b0010);
    chk("par_rd2", 64'(m_rdata[2]), 64'h5555_0000);
    chk("par_rd1", 64'(m_rdata[1]), 64'h0);
    tick();
    m_req[2] = 1'b0; s_ack[4] = 1'b0;
    s_ack[3] = 1'b1; s_rdata[3] = 32'h0000_0077;
    #1;
    chk("par_sreq3", 64'(s_req), 64'b0100);
    chk("par_ack1", 64'(m_ack), 64'b0001);
    chk("par_rd1b", 64'(m_rdata[1]), 64'h77);
    tick();
    m_req = '0; s_ack = '0; m_cmd = '0; m_wdata = '0;
    #1;

    // locked grant: M2 holds S1 while M3 waits
    m_req[2] = 1'b1; m_addr[2] = 32'h0000_0020;
    tick();
    m_req[3] = 1'b1; m_addr[3] = 32'h0000_0030;
    #1;
    chk("lock_addr", 64'(s_addr[1]), 64'h20);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("lock_hold", 64'(s_addr[1]), 64'h20);
    end
    s_ack[1] = 1'b1;
    #1;
    chk("lock_ack", 64'(m_ack), 64'b0010);
    tick();
    m_req[2] = 1'b0; s_ack[1] = 1'b0;
    #1;
    chk("lock_bub", 64'(s_req), 64'h0);
    tick();
    chk("lock_m3", 64'(s_req), 64'b0001);
    chk("lock_a3", 64'(s_addr[1]), 64'h30);
    s_ack[1] = 1'b1;
    #1;
    chk("lock_ack3", 64'(m_ack), 64'b0100);
    tick();
    m_req = '0; s_ack = '0;
    #1;

    // unmapped on the 3-slave instance
    b_m_req[4] = 1'b1; b_m_addr[4] = 32'hC000_0000;
    #1;
    chk("um_lat0", 64'(b_m_ack), 64'h0);
    tick();
    chk("um_ack", 64'(b_m_ack), 64'b1000);
    chk("um_rd", 64'(b_m_rdata[4]), 64'h0);
    chk("um_sreq", 64'(b_s_req), 64'h0);
    tick();
    chk("um_gap", 64'(b_m_ack), 64'h0);
    tick();
    chk("um_ack2", 64'(b_m_ack), 64'b1000);
    b_m_req = '0;
    #1;

    // park S2 pointer at 3, then reset mid-transfer
    m_req[3] = 1'b1; m_addr[3] = 32'h4000_0000;
    tick();
    chk("rs_m3", 64'(s_req), 64'b0010);
    s_ack[2] = 1'b1;
    #1;
    tick();
    m_req[3] = 1'b0; s_ack[2] = 1'b0;
    m_req[1] = 1'b1; m_addr[1] = 32'h4000_0000;
    tick();
    chk("rs_busy", 64'(s_req), 64'b0010);
    aresetn = 1'b0;
    s_ack[2] = 1'b1;
    #1;
    chk("rs_async", 64'(s_req), 64'h0);
    chk("rs_noack", 64'(m_ack), 64'h0);
    m_req = '0; s_ack = '0;
    tick();
    aresetn = 1'b1;
    m_req[3] = 1'b1; m_addr[3] = 32'h4000_0000;
    m_req[4] = 1'b1; m_addr[4] = 32'h4000_0004;
    tick();
    chk("rs_grant", 64'(s_addr[2]), 64'h4000_0000);
    s_ack[2] = 1'b1;
    #1;
    chk("rs_ack3", 64'(m_ack), 64'b0100);
    tick();
    m_req = '0; s_ack = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cross_bar_rr.md
Name: cross_bar_rr

Overview:
- Parametrised MASTER_N x SLAVE_N request/acknowledge crossbar. Successor to the fixed-routing crossbar.
- Each master request is routed to a slave by decoding the top address bits. Each slave has its own round-robin arbiter with a locked grant.
- Sits between the CPU/DMA masters and the memory/peripheral slaves. Adds contention handling and an unmapped-address response.

Parameters:
- MASTER_N, 4, number of masters (2..16)
- SLAVE_N, 4, number of slaves (1..16); need not be a power of two
- ADDR_W, 32, address width
- DATA_W, 32, data width
- SEL_W, $clog2(SLAVE_N) (min 1), number of top address bits used as the slave index

Ports:
- clk  input  1  clock
- aresetn  input  1  asynchronous active-low reset
- master_req  input  [MASTER_N:1]  request; held until ack
- master_addr  input  [MASTER_N:1][ADDR_W]  address
- master_cmd  input  [MASTER_N:1]  0 = read, 1 = write
- master_wdata  input  [MASTER_N:1][DATA_W]  write data
- master_ack  output  [MASTER_N:1]  single-cycle completion
- master_rdata  output  [MASTER_N:1][DATA_W]  read data, valid with ack
- slave_req  output  [SLAVE_N:1]  request to slave
- slave_addr  output  [SLAVE_N:1][ADDR_W]  forwarded address, unmodified
- slave_cmd  output  [SLAVE_N:1]  forwarded cmd
- slave_wdata  output  [SLAVE_N:1][DATA_W]  forwarded wdata
- slave_ack  input  [SLAVE_N:1]  slave completion
- slave_rdata  input  [SLAVE_N:1][DATA_W]  read data, valid with slave_ack

Behaviour:
- Clock and reset: one clock, clk. Reset aresetn is asynchronous and active-low.
- Reset values:
  - All grants cleared; every arbiter in IDLE.
  - Round-robin pointers = MASTER_N, so master 1 has top priority.
  - All slave_* and master_* outputs 0.
- Decode: target = master_addr[ADDR_W-1 -: SEL_W] + 1. If target > SLAVE_N, the address is unmapped.
- Per-slave arbiter, 2 states:
  - IDLE: the candidates are masters with req=1 and target == this slave. If there is any candidate, pick the first one after the pointer (cyclic search). Register the grant and go to BUSY. slave_req stays 0 in IDLE.
  - BUSY: slave_req/addr/cmd/wdata = the granted master's signals, combinationally. Other masters are ignored (grant locked).
    - slave_ack=1: master_ack[g]=1 and master_rdata[g]=slave_rdata in the same cycle; pointer <= g; next state IDLE.
    - Granted master drops req before ack (protocol violation): slave_req falls with it; next state IDLE; no ack forwarded; pointer unchanged.
- Latency:
  - Request to slave_req: 1 cycle.
  - slave_ack to master_ack: 0 cycles.
  - Back-to-back transactions on one slave have a 1-cycle IDLE bubble between them.
- A master still holding req in the cycle after its ack starts a new transaction.
- Unmapped address:
  - Internal error responder acks 1 cycle after the req is seen, with master_rdata=0.
  - It uses a per-master 1-bit flag that clears after the ack, so a held req yields an ack every 2 cycles.
  - No slave sees the request.
- Master return mux: each master is granted by at most one slave (or the error responder). When not acked, master_ack=0 and master_rdata=0.
- Slave outputs are 0 when not granted, the same as the disconnected mux select.
- Masters targeting different slaves proceed fully in parallel.
- Reset asserted mid-transaction: all state is cleared immediately. No ack is emitted for the in-flight transfer.

Decomposition:
- cross_bar_pkg:
  - MASTER_N, SLAVE_N, MASTER_W, SLAVE_W, addr_t, data_t
  - master_num_t/slave_num_t typedefs (0 = none)
  - arb_state_t enum {ARB_IDLE, ARB_BUSY}
- Sub-module cross_bar_rr_arb: one per slave via generate. It contains the state, grant and pointer registers and the cyclic priority search. The top level holds decode, muxes and the error responder.

Test Plan:
- Single read: M1 req, addr 0x4000_0000 (S2), cmd=0. S2 acks 3 cycles after its req with rdata 0xDEAD_BEEF -> slave_req[2] rises 1 cycle after M1 req; master_ack[1]=1 with rdata 0xDEAD_BEEF in the same cycle as slave_ack; all other outputs 0.
- Contention: M1..M4 all req S1 (addr 0x0000_0010), slave acks every BUSY cycle -> grants in order 1,2,3,4. After M1 re-requests, the next order starts at M2.
- Parallel: M1 -> S3 (0x8000_0000) write wdata 0x1234, M2 -> S4 (0xC000_0000) read, in the same cycle -> both slave_req asserted in the same cycle; acks independent; no cross-talk.
- Locked grant: M2 holds S1 BUSY for 5 cycles while M3 requests S1 -> slave_addr[1] stays M2's address until slave_ack; M3 is granted in the cycle after the IDLE bubble.
- Unmapped: SLAVE_N=3, M4 addr 0xC000_0000 -> master_ack[4]=1 with rdata 0 one cycle later; slave_req all 0.
- Reset mid-op: aresetn low while S2 is BUSY -> slave_req[2]=0 asynchronously; no master_ack. After release, a new M3 request is granted with master 1-first priority.
